sine_period_detector: RTL and testbench



---
 rtl/sine_period_detector_if.sv | 26 ++
 rtl/sine_period_detector.sv | 153 +++++++++++++++
 tb/tb_sine_period_detector.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sine_period_detector_if.sv
// Sample stream in, period/peak measurement out, for sine_period_detector.
// master drives samples and reads measurements; slave is the detector.
interface sine_period_detector_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              meas_valid;
  logic [CNT_W-1:0]  period;
  logic [DATA_W-1:0] pk_max;
  logic [DATA_W-1:0] pk_min;
  logic [DATA_W-1:0] pk2pk;
  logic              locked;
  logic              lost;

  modport master (
    output s_valid, s_data,
    input  meas_valid, period, pk_max, pk_min, pk2pk, locked, lost
  );

  modport slave (
    input  s_valid, s_data,
    output meas_valid, period, pk_max, pk_min, pk2pk, locked, lost
  );
endinterface

// File: rtl/sine_period_detector.sv
// Rising-midline-crossing period and peak meter for an unsigned sample stream.
// Optional SWG_ADAPTIVE_MID_EN re-centres the thresholds on every measurement.
module sine_period_detector #(
  parameter int DATA_W = 16,
  parameter int MID    = 1000,
  parameter int HYST   = 50,
  parameter int CNT_W  = 16
) (
  input logic                   clk,
  input logic                   rst,
  sine_period_detector_if.slave bus
);

  typedef enum logic [1:0] {SEARCH, LOW, HIGH} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              first_seen;
  logic [DATA_W-1:0] trk_max;
  logic [DATA_W-1:0] trk_min;

  logic              vld_p1;
  logic [CNT_W-1:0]  period_p1;
  logic [DATA_W-1:0] max_p1;
  logic [DATA_W-1:0] min_p1;
  logic [DATA_W-1:0] p2p_p1;
  logic              locked_p1;
  logic              lost_p1;

  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              at_hi;
  logic              at_lo;
  logic              rising;

  function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

`ifdef SWG_ADAPTIVE_MID_EN
  logic [DATA_W-1:0] centre;

  function automatic logic [DATA_W-1:0] add_hyst_sat(input logic [DATA_W-1:0] c);
    logic [DATA_W:0] s;
    s = {1'b0, c} + (DATA_W+1)'(HYST);
    return s[DATA_W] ? '1 : s[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] sub_hyst_floor(input logic [DATA_W-1:0] c);
    return (c < DATA_W'(HYST)) ? '0 : c - DATA_W'(HYST);
  endfunction

  function automatic logic [DATA_W-1:0] midpoint(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_W:1];
  endfunction

  assign hi = add_hyst_sat(centre);
  assign lo = sub_hyst_floor(centre);
`else
  assign hi = DATA_W'(MID + HYST);
  assign lo = DATA_W'(MID - HYST);
`endif

  // p0: accepted sample and its threshold classification
  assign vld_p0  = bus.s_valid;
  assign data_p0 = bus.s_data;
  assign at_hi   = (data_p0 >= hi);
  assign at_lo   = (data_p0 <= lo);
  assign rising  = (state == LOW) && at_hi;

  // p1: registered measurement outputs plus crossing FSM, counter and trackers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SEARCH;
      cnt        <= '0;
      first_seen <= 1'b0;
      trk_max    <= '0;
      trk_min    <= '0;
      vld_p1     <= 1'b0;
      period_p1  <= '0;
      max_p1     <= '0;
      min_p1     <= '0;
      p2p_p1     <= '0;
      locked_p1  <= 1'b0;
      lost_p1    <= 1'b0;
`ifdef SWG_ADAPTIVE_MID_EN
      centre     <= DATA_W'(MID);
`endif
    end else begin
      vld_p1  <= 1'b0;
      lost_p1 <= 1'b0;
      if (vld_p0) begin
        if (rising) begin
          // A crossing beats saturation, so a saturated count still reports.
          state      <= HIGH;
          cnt        <= CNT_W'(1);
          first_seen <= 1'b1;
          trk_max    <= data_p0;
          trk_min    <= data_p0;
          if (first_seen) begin
            vld_p1    <= 1'b1;
            period_p1 <= cnt;
            max_p1    <= trk_max;
            min_p1    <= trk_min;
            p2p_p1    <= trk_max - trk_min;
            locked_p1 <= 1'b1;
`ifdef SWG_ADAPTIVE_MID_EN
            centre    <= midpoint(trk_max, trk_min);
`endif
          end
        end else if (cnt == CNT_MAX) begin
          // Counter restarts so one loss yields exactly one lost pulse.
          state      <= SEARCH;
          cnt        <= '0;
          first_seen <= 1'b0;
          lost_p1    <= 1'b1;
          locked_p1  <= 1'b0;
`ifdef SWG_ADAPTIVE_MID_EN
          centre     <= DATA_W'(MID);
`endif
        end else begin
          cnt <= cnt_inc_sat(cnt);
          if (data_p0 > trk_max) trk_max <= data_p0;
          if (data_p0 < trk_min) trk_min <= data_p0;
          case (state)
            SEARCH: begin
              if (at_lo)      state <= LOW;
              else if (at_hi) state <= HIGH;
            end
            HIGH:    if (at_lo) state <= LOW;
            default: state <= state;
          endcase
        end
      end
    end
  end

  assign bus.meas_valid = vld_p1;
  assign bus.period     = period_p1;
  assign bus.pk_max     = max_p1;
  assign bus.pk_min     = min_p1;
  assign bus.pk2pk      = p2p_p1;
  assign bus.locked     = locked_p1;
  assign bus.lost       = lost_p1;

endmodule

// File: tb/tb_sine_period_detector.sv
// Self-checking bench for sine_period_detector: vector table, directed corners,
// and randomized sine/noise stimulus against a behavioural model.
module tb_sine_period_detector;

  localparam int DW   = 16;
  localparam int HI_T = 1050;
  localparam int LO_T = 950;
  localparam int CMAX = 65535;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sine_period_detector_if #(.DATA_W(DW), .CNT_W(16)) bus ();
  sine_period_detector_if #(.DATA_W(DW), .CNT_W(8))  bus8 ();

  sine_period_detector #(.DATA_W(DW), .MID(1000), .HYST(50), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  sine_period_detector #(.DATA_W(DW), .MID(1000), .HYST(50), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8)
  );

  int total = 0;
  int bad   = 0;
  int tbl[64];

  typedef struct {
    bit v;
    int d;
    bit em;
    int ep;
    int emax;
    int emin;
    int ep2p;
    bit elk;
  } vec_t;
  vec_t vecs[129];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: zone tracking plus the list of samples seen since the last crossing.
  int m_zone;      // 0 undecided, 1 below lo, 2 above hi
  bit m_armed;
  int m_count;
  int q[$];
  bit e_meas, e_lost, e_locked;
  int e_period, e_max, e_min, e_p2p;

  function automatic void model_reset();
    m_zone = 0; m_armed = 0; m_count = 0; q.delete();
    e_meas = 0; e_lost = 0; e_locked = 0;
    e_period = 0; e_max = 0; e_min = 0; e_p2p = 0;
  endfunction

  function automatic void model_step(input bit v, input int d);
    int mx, mn;
    e_meas = 0;
    e_lost = 0;
    if (!v) return;
    if (m_zone == 1 && d >= HI_T) begin
      if (m_armed) begin
        mx = q[0]; mn = q[0];
        foreach (q[i]) begin
          if (q[i] > mx) mx = q[i];
          if (q[i] < mn) mn = q[i];
        end
        e_meas = 1; e_locked = 1;
        e_period = (m_count > CMAX) ? CMAX : m_count;
        e_max = mx; e_min = mn; e_p2p = mx - mn;
      end
      m_armed = 1; m_zone = 2; m_count = 1;
      q.delete(); q.push_back(d);
    end else if (m_count >= CMAX) begin
      e_lost = 1; e_locked = 0; m_armed = 0; m_zone = 0; m_count = 0;
      q.delete();
    end else begin
      m_count++;
      q.push_back(d);
      if (d <= LO_T) m_zone = 1;
      else if (d >= HI_T) m_zone = 2;
    end
  endfunction

  task automatic step(input bit v, input int d);
    @(negedge clk);
    bus.s_valid = v;
    bus.s_data  = DW'(d);
    @(posedge clk);
    #1;
    model_step(v, d);
    chk("mdl_meas_valid", bus.meas_valid, e_meas);
    chk("mdl_lost",       bus.lost,       e_lost);
    chk("mdl_locked",     bus.locked,     e_locked);
    chk("mdl_period",     bus.period,     e_period);
    chk("mdl_pk_max",     bus.pk_max,     e_max);
    chk("mdl_pk_min",     bus.pk_min,     e_min);
    chk("mdl_pk2pk",      bus.pk2pk,      e_p2p);
  endtask

  task automatic step8(input bit v, input int d);
    @(negedge clk);
    bus8.s_valid = v;
    bus8.s_data  = DW'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.s_valid  = 1'b0;
    bus8.s_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int nmeas, mcyc, cyc, lostpos, nlost, d, per, amp, noise;
    real ph;

    for (int i = 0; i < 64; i++)
      tbl[i] = $rtoi(1000.0 + 1000.0 * $sin(2.0 * 3.14159265358979 * i / 64.0) + 0.5);
    model_reset();

    // Reset held with live random samples: everything stays zero.
    bus.s_valid = 1'b1; bus8.s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.s_data  = DW'($urandom_range(0, 2000));
      bus8.s_data = DW'($urandom_range(0, 2000));
      @(posedge clk); #1;
      chk("rst_meas_valid", bus.meas_valid, 0);
      chk("rst_period", bus.period, 0);
      chk("rst_pk_max", bus.pk_max, 0);
      chk("rst_pk_min", bus.pk_min, 0);
      chk("rst_pk2pk",  bus.pk2pk,  0);
      chk("rst_locked", bus.locked, 0);
      chk("rst_lost",   bus.lost,   0);
      chk("rst8_locked", bus8.locked, 0);
    end
    @(negedge clk);
    rst = 1'b0; bus.s_valid = 1'b0; bus8.s_valid = 1'b0;

    // Inside the hysteresis band nothing ever crosses.
    nmeas = 0;
    for (int i = 0; i < 500; i++) begin
      step(1'b1, (i % 2) ? 1040 : 990);
      if (bus.meas_valid) nmeas++;
    end
    chk("band_meas_count", nmeas, 0);

    // Vector table: prime below lo, then the 64-entry table twice.
    do_reset();
    vecs[0] = '{v:1, d:0, em:0, ep:0, emax:0, emin:0, ep2p:0, elk:0};
    for (int k = 0; k < 128; k++) begin
      if (k < 65)
        vecs[k+1] = '{v:1, d:tbl[k%64], em:0, ep:0, emax:0, emin:0, ep2p:0, elk:0};
      else
        vecs[k+1] = '{v:1, d:tbl[k%64], em:(k == 65), ep:64, emax:2000, emin:0, ep2p:2000, elk:1};
    end
    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].d);
      chk("vec_meas_valid", bus.meas_valid, vecs[i].em);
      chk("vec_period", bus.period, vecs[i].ep);
      chk("vec_pk_max", bus.pk_max, vecs[i].emax);
      chk("vec_pk_min", bus.pk_min, vecs[i].emin);
      chk("vec_pk2pk",  bus.pk2pk,  vecs[i].ep2p);
      chk("vec_locked", bus.locked, vecs[i].elk);
    end

    // Same stream with every other cycle idle.
    do_reset();
    cyc = 0; nmeas = 0; mcyc = -1; per = -1;
    step(1'b1, 0); cyc++;
    for (int k = 0; k < 128; k++) begin
      step(1'b1, tbl[k%64]); cyc++;
      if (bus.meas_valid) begin nmeas++; mcyc = cyc; per = bus.period; end
      step(1'b0, $urandom_range(0, 2000)); cyc++;
      if (bus.meas_valid) nmeas++;
    end
    chk("gap_meas_count", nmeas, 1);
    chk("gap_meas_cycle", mcyc, 132);
    chk("gap_period", per, 64);

    // 32-sample loop, three passes: two measurements.
    do_reset();
    nmeas = 0;
    step(1'b1, 0);
    for (int k = 0; k < 96; k++) begin
      step(1'b1, tbl[(2*k) % 64]);
      if (bus.meas_valid) begin
        nmeas++;
        chk("l32_period", bus.period, 32);
        chk("l32_pk_max", bus.pk_max, 2000);
        chk("l32_pk_min", bus.pk_min, 0);
      end
    end
    chk("l32_meas_count", nmeas, 2);

    // Randomized sine bursts with noise and random gaps, against the model.
    do_reset();
    for (int s = 0; s < 12; s++) begin
      per = $urandom_range(12, 90);
      amp = $urandom_range(30, 1000);
      noise = $urandom_range(0, 40);
      for (int i = 0; i < 3 * per; i++) begin
        ph = 2.0 * 3.14159265358979 * i / per;
        d = $rtoi(1000.0 + amp * $sin(ph) + 0.5) + $urandom_range(0, 2*noise) - noise;
        if (d < 0) d = 0;
        if (d > 2047) d = 2047;
        if ($urandom_range(0, 3) == 0) step(1'b0, $urandom_range(0, 2047));
        step(1'b1, d);
      end
    end
    for (int i = 0; i < 300; i++) step($urandom_range(0, 1), $urandom_range(0, 2047));

    // Narrow counter: lock, then starve it of crossings until it saturates.
    do_reset();
    nmeas = 0;
    step8(1'b1, 0);
    for (int k = 0; k < 128; k++) begin
      step8(1'b1, tbl[k%64]);
      if (bus8.meas_valid) nmeas++;
    end
    chk("c8_meas_count", nmeas, 1);
    chk("c8_period", bus8.period, 64);
    chk("c8_locked", bus8.locked, 1);
    nlost = 0; lostpos = -1;
    for (int j = 1; j <= 250; j++) begin
      step8(1'b1, 1000);
      if (bus8.lost) begin
        nlost++;
        if (lostpos < 0) lostpos = j;
      end
    end
    chk("c8_lost_count", nlost, 1);
    chk("c8_lost_pos", lostpos, 193);
    chk("c8_locked_after_loss", bus8.locked, 0);
    chk("c8_period_hold", bus8.period, 64);
    chk("c8_pk2pk_hold", bus8.pk2pk, 2000);

    step8(1'b1, 0);
    for (int k = 0; k < 86; k++) step8(1'b1, tbl[k%64]);
    chk("c8_relocked", bus8.locked, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_locked", bus8.locked, 0);
    chk("arst_period", bus8.period, 0);
    chk("arst_pk_max", bus8.pk_max, 0);
    chk("arst_pk_min", bus8.pk_min, 0);
    chk("arst_pk2pk",  bus8.pk2pk,  0);
    chk("arst_meas_valid", bus8.meas_valid, 0);
    chk("arst_lost", bus8.lost, 0);
    @(negedge clk);
    rst = 1'b0;
    bus8.s_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
